// File: rtl/serial_adder.sv
// Bit-serial adder: accepts a, b, cin in IDLE, adds one bit per cycle LSB-first over WIDTH
// RUN cycles, then holds sum/cout in DONE until the consumer handshakes.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic ha1_s, ha1_c, ha2_s, ha2_c, bit_c, last_bit;

  // One-bit full adder as two half-adder stages plus OR.
  always_comb begin
    ha1_s    = a_q[0] ^ b_q[0];
    ha1_c    = a_q[0] & b_q[0];
    ha2_s    = ha1_s ^ carry_q;
    ha2_c    = ha1_s & carry_q;
    bit_c    = ha1_c | ha2_c;
    last_bit = (cnt_q == CntW'(WIDTH - 1));
  end

  // Next-state and datapath update; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        // Sum bits enter from the MSB side so bit 0 lands in place after WIDTH shifts.
        sum_d   = {ha2_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = bit_c;
        cnt_d   = cnt_q + CntW'(1);
        if (last_bit) begin
          cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB on the last bit.
          ovf_d   = carry_q ^ bit_c;
`endif
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): vector table, random operands against an
// arithmetic reference, and hand-written hold / reset / throughput sequences.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           hold;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer addition; signed overflow from operand/result sign bits.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] full;
    full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    s    = full[W-1:0];
    co   = full[W];
    ov   = (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);
  endtask

  task automatic drive_junk();
    in_valid  = 1'($urandom);
    a         = W'($urandom);
    b         = W'($urandom);
    cin       = 1'($urandom);
  endtask

  // Full transaction with junk on inputs outside IDLE, result hold, and handshake.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic [W-1:0] es, input logic ec, input logic eo,
                        input int hold, input string tag);
    int   lat;
    logic got;
    @(negedge clk);
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    out_ready = 1'($urandom);
    @(posedge clk); #1;
    check({tag, " busy after accept"}, 32'(busy), 32'd1);
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= W + 4 && !got; k++) begin
      drive_junk();
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      if (out_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(W));
    if (!got) begin
      in_valid = 1'b0;
      return;
    end
    out_ready = 1'b0;
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected x in ovf expectation");
`endif
    check({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
    check({tag, " busy in DONE"}, 32'(busy), 32'd0);
    for (int h = 0; h < hold; h++) begin
      drive_junk();
      @(posedge clk); #1;
      check({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " held sum"}, 32'(sum), 32'(es));
      check({tag, " held cout"}, 32'(cout), 32'(ec));
      check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    logic [W-1:0] ra, rb, rs;
    logic         rc, rco, rov;
    int           nv;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0, hold: 0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0, hold: 1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0, hold: 0};
    vecs[3] = '{a: 8'h12, b: 8'h34, cin: 1'b0, sum: 8'h46, cout: 1'b0, ovf: 1'b0, hold: 5};
    vecs[4] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1, hold: 2};
    vecs[5] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0, ovf: 1'b0, hold: 0};
    vecs[6] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1, hold: 3};
    vecs[7] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0, hold: 0};

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset cout", 32'(cout), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;

    // Directed vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf,
             vecs[i].hold, $sformatf("vec%0d", i));
    end

    // Reset during RUN at bit 4 abandons the operation.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    check("rst_run in_ready", 32'(in_ready), 32'd1);
    check("rst_run out_valid", 32'(out_valid), 32'd0);
    check("rst_run busy", 32'(busy), 32'd0);
    check("rst_run sum", 32'(sum), 32'd0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, "after_rst_run");

    // Reset in DONE dominates out_ready and in_valid; no result is emitted afterwards.
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    check("rst_done reached DONE", 32'(out_valid), 32'd1);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    check("rst_done out_valid", 32'(out_valid), 32'd0);
    check("rst_done sum", 32'(sum), 32'd0);
    check("rst_done cout", 32'(cout), 32'd0);
    check("rst_done in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("rst_done stays idle", 32'(in_ready), 32'd1);

    // Randomized operands against the arithmetic reference.
    for (int r = 0; r < 40; r++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if (r == 0) begin ra = 8'hFF; rb = 8'h01; rc = 1'b0; end
      model(ra, rb, rc, rs, rco, rov);
      run_op(ra, rb, rc, rs, rco, rov, $urandom_range(0, 3), $sformatf("rand%0d", r));
    end

    // Throughput: in_valid and out_ready tied high give one result per W+2 cycles.
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    nv = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 3 * (W + 2); k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        nv++;
        check("thru sum", 32'(sum), 32'h10);
      end
    end
    check("thru results", 32'(nv), 32'd3);
    in_valid = 1'b0;
    for (int k = 0; k < 3 * W && !in_ready; k++) begin
      @(posedge clk); #1;
    end
    check("thru drained", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
